// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture path: active-low digit patterns,
// capture FSM states and the decimal wrap-around helper.
package seg7_pkg;

    // Patterns are active-low with index 0 = segment a ... index 6 = segment g.
    localparam logic [0:6] SEG_0     = 7'b0000001;
    localparam logic [0:6] SEG_1     = 7'b1001111;
    localparam logic [0:6] SEG_2     = 7'b0010010;
    localparam logic [0:6] SEG_3     = 7'b0000110;
    localparam logic [0:6] SEG_4     = 7'b1001100;
    localparam logic [0:6] SEG_5     = 7'b0100100;
    localparam logic [0:6] SEG_6     = 7'b1100000;
    localparam logic [0:6] SEG_7     = 7'b0001111;
    localparam logic [0:6] SEG_8     = 7'b0000000;
    localparam logic [0:6] SEG_9     = 7'b0001100;
    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } state_e;

    function automatic logic [3:0] next_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the BCD-to-7-segment encoder: maps an active-low
// segment pattern back to its digit and flags blank and illegal patterns.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [0:6] pattern,
    output logic [3:0] value,
    output logic       legal,
    output logic       is_blank
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        value    = 4'd0;
        legal    = 1'b1;
        is_blank = 1'b0;
        case (pattern)
            SEG_0:     value = 4'd0;
            SEG_1:     value = 4'd1;
            SEG_2:     value = 4'd2;
            SEG_3:     value = 4'd3;
            SEG_4:     value = 4'd4;
            SEG_5:     value = 4'd5;
            SEG_6:     value = 4'd6;
            SEG_7:     value = 4'd7;
            SEG_8:     value = 4'd8;
            SEG_9:     value = 4'd9;
            SEG_BLANK: begin
                legal    = 1'b0;
                is_blank = 1'b1;
            end
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_capture.sv
// Glitch-filtering 7-segment monitor: accepts a pattern after STABLE_CYCLES of
// stability and decodes it. Define SEG7_SEQ_CHECK_EN to enable 0..9 sequence checking.
module seg7_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [0:6] seg,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       invalid,
    output logic       blank,
    output logic       seq_err,
    output logic [7:0] accept_cnt
);

    localparam logic [3:0] CNT_LAST = 4'(STABLE_CYCLES - 1);

    logic [0:6] seg_q, seg_d;
    logic [0:6] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    state_e     state_q, state_d;
    logic [3:0] digit_q, digit_d;
    logic       digit_valid_q, digit_valid_d;
    logic       invalid_q, invalid_d;
    logic       blank_q, blank_d;
    logic [7:0] accept_cnt_q, accept_cnt_d;

    logic [3:0] dec_value;
    logic       dec_legal;
    logic       dec_blank;

`ifdef SEG7_SEQ_CHECK_EN
    logic [3:0] prev_q, prev_d;
    logic       hist_q, hist_d;
    logic       seq_err_q, seq_err_d;
`endif

    // Acceptance only happens while seg_q == cand, so decoding cand is sufficient.
    seg7_decode u_decode (
        .pattern  (cand_q),
        .value    (dec_value),
        .legal    (dec_legal),
        .is_blank (dec_blank)
    );

    always_comb begin
        seg_d         = seg;
        cand_d        = cand_q;
        cnt_d         = cnt_q;
        state_d       = state_q;
        digit_d       = digit_q;
        digit_valid_d = 1'b0;
        invalid_d     = 1'b0;
        blank_d       = blank_q;
        accept_cnt_d  = accept_cnt_q;
`ifdef SEG7_SEQ_CHECK_EN
        prev_d        = prev_q;
        hist_d        = hist_q;
        seq_err_d     = 1'b0;
`endif

        // A change restarts tracking even on the edge that would have accepted.
        if (seg_q != cand_q) begin
            cand_d  = seg_q;
            cnt_d   = 4'd1;
            state_d = TRACK;
        end else if (state_q == TRACK) begin
            if (cnt_q < CNT_LAST) begin
                cnt_d = cnt_q + 4'd1;
            end else begin
                state_d = HOLD;
                if (dec_legal) begin
                    digit_d       = dec_value;
                    digit_valid_d = 1'b1;
                    blank_d       = 1'b0;
                    if (accept_cnt_q != 8'hFF) accept_cnt_d = accept_cnt_q + 8'd1;
`ifdef SEG7_SEQ_CHECK_EN
                    seq_err_d = hist_q && (dec_value != next_digit(prev_q));
                    prev_d    = dec_value;
                    hist_d    = 1'b1;
`endif
                end else if (dec_blank) begin
                    blank_d = 1'b1;
`ifdef SEG7_SEQ_CHECK_EN
                    hist_d  = 1'b0;
`endif
                end else begin
                    invalid_d = 1'b1;
                    blank_d   = 1'b0;
`ifdef SEG7_SEQ_CHECK_EN
                    hist_d    = 1'b0;
`endif
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            seg_q         <= SEG_BLANK;
            cand_q        <= SEG_BLANK;
            cnt_q         <= 4'd0;
            state_q       <= IDLE;
            digit_q       <= 4'd0;
            digit_valid_q <= 1'b0;
            invalid_q     <= 1'b0;
            blank_q       <= 1'b0;
            accept_cnt_q  <= 8'd0;
        end else begin
            seg_q         <= seg_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            invalid_q     <= invalid_d;
            blank_q       <= blank_d;
            accept_cnt_q  <= accept_cnt_d;
        end
    end

`ifdef SEG7_SEQ_CHECK_EN
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            prev_q    <= 4'd0;
            hist_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            hist_q    <= hist_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

    assign digit       = digit_q;
    assign digit_valid = digit_valid_q;
    assign invalid     = invalid_q;
    assign blank       = blank_q;
    assign accept_cnt  = accept_cnt_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed self-checking bench for seg7_capture (STABLE_CYCLES=4); expectations
// follow SEG7_SEQ_CHECK_EN when it is defined for the build.
module tb_seg7_capture;

    localparam logic [0:6] P0 = 7'b0000001;
    localparam logic [0:6] P2 = 7'b0010010;
    localparam logic [0:6] P3 = 7'b0000110;
    localparam logic [0:6] P4 = 7'b1001100;
    localparam logic [0:6] P8 = 7'b0000000;
    localparam logic [0:6] P9 = 7'b0001100;
    localparam logic [0:6] PB = 7'b1111111;
    localparam logic [0:6] PX = 7'b1111110;

`ifdef SEG7_SEQ_CHECK_EN
    localparam int SEQ_ON = 1;
`else
    localparam int SEQ_ON = 0;
`endif

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [0:6] seg;
    logic [3:0] digit;
    logic       digit_valid;
    logic       invalid;
    logic       blank;
    logic       seq_err;
    logic [7:0] accept_cnt;

    int errors = 0;
    int checks = 0;
    int dv_n, inv_n, se_n;
    bit wide_pulse = 1'b0;
    bit se_alone   = 1'b0;
    bit last_dv = 1'b0, last_inv = 1'b0, last_se = 1'b0;

    seg7_capture #(.STABLE_CYCLES(4)) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .seg         (seg),
        .digit       (digit),
        .digit_valid (digit_valid),
        .invalid     (invalid),
        .blank       (blank),
        .seq_err     (seq_err),
        .accept_cnt  (accept_cnt)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        dv_n  = 0;
        inv_n = 0;
        se_n  = 0;
    endtask

    // Advance n cycles, sampling outputs on the falling edge after each rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            @(negedge Clock);
            if (digit_valid) dv_n++;
            if (invalid) inv_n++;
            if (seq_err) se_n++;
            if ((digit_valid && last_dv) || (invalid && last_inv) || (seq_err && last_se))
                wide_pulse = 1'b1;
            if (seq_err && !digit_valid) se_alone = 1'b1;
            last_dv  = digit_valid;
            last_inv = invalid;
            last_se  = seq_err;
        end
    endtask

    initial begin
        Resetn = 1'b0;
        seg    = PB;
        clear_counts();
        repeat (2) @(negedge Clock);
        check("rst_digit", digit, 0);
        check("rst_valid", digit_valid, 0);
        check("rst_invalid", invalid, 0);
        check("rst_blank", blank, 0);
        check("rst_seq_err", seq_err, 0);
        check("rst_accept_cnt", accept_cnt, 0);
        Resetn = 1'b1;

        // Blank input matching the reset candidate is never tracked.
        step(6);
        check("idle_no_pulse", dv_n + inv_n, 0);
        check("idle_blank", blank, 0);

        // First digit: pulse appears at E0+4, i.e. the fifth sampled edge.
        clear_counts();
        seg = P2;
        step(4);
        check("d2_early", dv_n, 0);
        step(1);
        check("d2_valid", digit_valid, 1);
        check("d2_digit", digit, 2);
        check("d2_cnt", accept_cnt, 1);
        step(4);
        check("d2_once", dv_n, 1);

        // Three-cycle glitch is filtered; the return to 2 is then re-accepted.
        clear_counts();
        seg = P3;
        step(3);
        seg = P2;
        step(4);
        check("glitch_pulses", dv_n + inv_n + se_n, 0);
        check("glitch_digit", digit, 2);
        step(1);
        check("reacc_valid", digit_valid, 1);
        check("reacc_cnt", accept_cnt, 2);
        check("reacc_seq_err", se_n, SEQ_ON);

        // Illegal pattern held long: a single invalid pulse, nothing else moves.
        clear_counts();
        seg = PX;
        step(10);
        check("ill_inv_once", inv_n, 1);
        check("ill_no_valid", dv_n, 0);
        check("ill_digit", digit, 2);
        check("ill_cnt", accept_cnt, 2);
        check("ill_blank", blank, 0);

        // 8, 9, 0 follow the count; 2 after 0 breaks it.
        clear_counts();
        seg = P8; step(6);
        seg = P9; step(6);
        seg = P0; step(6);
        check("seq_ok_err", se_n, 0);
        check("seq_ok_valid", dv_n, 3);
        check("seq_ok_digit", digit, 0);
        clear_counts();
        seg = P2; step(6);
        check("seq_bad_valid", dv_n, 1);
        check("seq_bad_err", se_n, SEQ_ON);
        check("seq_bad_digit", digit, 2);
        check("seq_bad_cnt", accept_cnt, 6);

        // Blank acceptance raises the level output without pulses.
        clear_counts();
        seg = PB; step(6);
        check("blank_level", blank, 1);
        check("blank_pulses", dv_n + inv_n + se_n, 0);

        // Reset in the middle of tracking (cnt=3) clears outputs immediately.
        clear_counts();
        seg = P3;
        step(4);
        #2 Resetn = 1'b0;
        #1;
        check("mid_rst_digit", digit, 0);
        check("mid_rst_cnt", accept_cnt, 0);
        check("mid_rst_blank", blank, 0);
        check("mid_rst_valid", digit_valid, 0);
        @(posedge Clock);
        @(negedge Clock);
        Resetn = 1'b1;
        clear_counts();
        step(4);
        check("post_rst_early", dv_n + inv_n + se_n, 0);
        step(1);
        check("post_rst_valid", digit_valid, 1);
        check("post_rst_digit", digit, 3);
        check("post_rst_cnt", accept_cnt, 1);
        check("post_rst_seq_err", seq_err, 0);

        // 300 acceptances alternating 4/3: counter saturates, every 4->3 step errors.
        clear_counts();
        for (int i = 0; i < 300; i++) begin
            seg = (i % 2 == 0) ? P4 : P3;
            step(5);
        end
        check("sat_valid", dv_n, 300);
        check("sat_cnt", accept_cnt, 255);
        check("sat_seq_err", se_n, 150 * SEQ_ON);
        check("sat_invalid", inv_n, 0);

        check("pulse_width", wide_pulse, 0);
        check("seq_err_alone", se_alone, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
